// File: rtl/sklansky_add_pipe.sv
// -----------------------------------------------------------------------------
// sklansky_add_pipe
//   Three-stage pipelined Sklansky parallel-prefix adder with a valid/ready
//   handshake on both sides.
//
//   Stage 1 : registers bitwise p = a^b, g = a&b and cin (generate of pos -1)
//   Stage 2 : first ceil(L/2) prefix levels, registers group (G,P) and p
//   Stage 3 : remaining levels, registers sum, cout and ovf
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand beat present
//   in_ready   : block can take an operand beat this cycle
//   a, b, cin  : operands and carry-in
//   out_valid  : result beat present
//   out_ready  : consumer takes the result beat
//   sum        : (a+b+cin) mod 2^WIDTH
//   cout       : carry out of bit WIDTH-1
//   ovf        : signed two's-complement overflow
// -----------------------------------------------------------------------------
module sklansky_add_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L  = $clog2(WIDTH);
    localparam int L1 = (L + 1) / 2;   // prefix levels evaluated in stage 2

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("sklansky_add_pipe: WIDTH must be a power of two in 4..64");
    end

    // ------------------------------------------------------------------
    // Valid chain. A stage may load when it is empty or is being drained
    // in the same cycle, so ready ripples back combinationally from
    // out_ready.
    // ------------------------------------------------------------------
    logic [3:1] vld_q, vld_d;
    logic [3:1] rdy;

    assign rdy[3]    = !vld_q[3] | out_ready;
    assign rdy[2]    = !vld_q[2] | rdy[3];
    assign rdy[1]    = !vld_q[1] | rdy[2];
    assign in_ready  = rdy[1];
    assign out_valid = vld_q[3];

    assign vld_d[1] = rdy[1] ? in_valid : vld_q[1];
    assign vld_d[2] = rdy[2] ? vld_q[1] : vld_q[2];
    assign vld_d[3] = rdy[3] ? vld_q[2] : vld_q[3];

    logic ld1, ld2, ld3;
    assign ld1 = rdy[1] & in_valid;
    assign ld2 = rdy[2] & vld_q[1];
    assign ld3 = rdy[3] & vld_q[2];

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p1_q, g1_q, p1_d, g1_d;
    logic             c1_q;

    logic [WIDTH-1:0] gg2_q, gp2_q, p2_q;   // group G/P after L1 levels, bit p
    logic             c2_q;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    assign p1_d = a ^ b;
    assign g1_d = a & b;

    // ------------------------------------------------------------------
    // Prefix network. gc/pc[k] is the (G,P) vector entering level k.
    // Level L1 takes its input from the stage-2 registers instead of the
    // combinational chain, which is where the pipeline cut sits.
    // Bit 0 is anchored to position -1 up front (grey cell with cin), so
    // every G produced later that reaches bit 0 already spans down to -1.
    // ------------------------------------------------------------------
    logic [L:0][WIDTH-1:0]   gc, pc;
    logic [L-1:0][WIDTH-1:0] gin, pin;

    always_comb begin
        gc[0]    = g1_q;
        gc[0][0] = g1_q[0] | (p1_q[0] & c1_q);
        pc[0]    = p1_q;
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        if (k == L1) begin : g_cut
            assign gin[k] = gg2_q;
            assign pin[k] = gp2_q;
        end else begin : g_chain
            assign gin[k] = gc[k];
            assign pin[k] = pc[k];
        end

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            // Sklansky: bit j with bit k set combines with the top of the
            // lower half of its 2^(k+1) block.
            localparam int S = ((j >> k) << k) - 1;
            if (((j >> k) & 1) == 0) begin : g_pass
                assign gc[k+1][j] = gin[k][j];
                assign pc[k+1][j] = pin[k][j];
            end else if (j < (2 << k)) begin : g_grey
                // span now reaches position -1: only G is meaningful
                assign gc[k+1][j] = gin[k][j] | (pin[k][j] & gin[k][S]);
                assign pc[k+1][j] = pin[k][j];
            end else begin : g_black
                assign gc[k+1][j] = gin[k][j] | (pin[k][j] & gin[k][S]);
                assign pc[k+1][j] = pin[k][j] & pin[k][S];
            end
        end
    end

    // group propagates out of the final level are never needed
    logic unused_pc;
    assign unused_pc = ^pc[L];

    // gc[L][i] = G[i:-1], the carry into bit i+1
    always_comb begin
        sum_d = p2_q ^ {gc[L][WIDTH-2:0], c2_q};
        cout_d = gc[L][WIDTH-1];
        ovf_d  = gc[L][WIDTH-2] ^ gc[L][WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            p1_q   <= '0;
            g1_q   <= '0;
            c1_q   <= 1'b0;
            gg2_q  <= '0;
            gp2_q  <= '0;
            p2_q   <= '0;
            c2_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (ld1) begin
                p1_q <= p1_d;
                g1_q <= g1_d;
                c1_q <= cin;
            end
            if (ld2) begin
                gg2_q <= gc[L1];
                gp2_q <= pc[L1];
                p2_q  <= p1_q;
                c2_q  <= c1_q;
            end
            if (ld3) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sklansky_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_sklansky_add_pipe
//   Self-checking bench for sklansky_add_pipe. A WIDTH=16 instance covers
//   reset, directed vectors, streaming, backpressure and mid-stream reset;
//   a WIDTH=4 instance is swept over every a, b, cin.
// -----------------------------------------------------------------------------
module tb_sklansky_add_pipe;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res16_t;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       o;
    } res4_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b1, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [3:0]  sum4;

    int checks = 0;
    int passes = 0;

    res16_t q16[$];
    res4_t  q4[$];

    always #5 clk = ~clk;

    sklansky_add_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    sklansky_add_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Reference models: plain integer arithmetic, overflow from signed range
    function automatic res16_t ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        res16_t r;
        logic [16:0] full;
        int sx, sy, sv;
        full = {1'b0, x} + {1'b0, y} + {16'd0, c};
        sx = int'($signed(x));
        sy = int'($signed(y));
        sv = sx + sy + int'(c);
        r.s = full[15:0];
        r.c = full[16];
        r.o = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    function automatic res4_t ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        res4_t r;
        logic [4:0] full;
        int sx, sy, sv;
        full = {1'b0, x} + {1'b0, y} + {4'd0, c};
        sx = int'($signed(x));
        sy = int'($signed(y));
        sv = sx + sy + int'(c);
        r.s = full[3:0];
        r.c = full[4];
        r.o = (sv > 7) || (sv < -8);
        return r;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
        else passes++;
        checks++;
        if ({sum, cout, ovf} !== 18'd0) $display("FAIL reset_outputs got=%h want=0", {sum, cout, ovf});
        else passes++;
        checks++;
        if (out_valid4 !== 1'b0) $display("FAIL reset_out_valid4 got=%b want=0", out_valid4);
        else passes++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b want=0", out_valid);
        else passes++;
    endtask

    // ------------------------------------------------------------------
    // Hand-computed single beats, each checked for exact 3-cycle latency
    task automatic test_directed();
        logic [15:0] va[8], vb[8], es[8];
        logic        vc[8], ec[8], eo[8];
        va = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000, 16'h0000, 16'hAAAA};
        vb = '{16'h0001, 16'h0000, 16'h8000, 16'h4321, 16'hFFFF, 16'h4000, 16'h0000, 16'h5555};
        vc = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
        es = '{16'h0000, 16'h8000, 16'h0000, 16'h5555, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000};
        ec = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        eo = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_lat1 out_valid got=%b want=0", i, out_valid);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_lat2 out_valid got=%b want=0", i, out_valid);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1) $display("FAIL dir%0d_lat3 out_valid got=%b want=1", i, out_valid);
            else passes++;
            checks++;
            if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]})
                $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_drain out_valid got=%b want=0", i, out_valid);
            else passes++;
        end
    endtask

    // ------------------------------------------------------------------
    // 1000 random beats, out_ready held high: one result per cycle
    task automatic test_back_to_back();
        int sent = 0;
        res16_t exp_r;
        q16.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 1007; k++) begin
            if (sent < 1000) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (out_valid !== (k >= 3 && k < 1003))
                $display("FAIL b2b_out_valid cyc=%0d got=%b want=%b", k, out_valid, (k >= 3 && k < 1003));
            else passes++;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", k, in_ready);
            else passes++;
            if (out_valid && out_ready) begin
                checks++;
                if (q16.size() == 0) $display("FAIL b2b_extra_beat cyc=%0d got=beat want=none", k);
                else begin
                    exp_r = q16.pop_front();
                    if ({sum, cout, ovf} !== exp_r)
                        $display("FAIL b2b_result cyc=%0d got=%h want=%h", k, {sum, cout, ovf}, exp_r);
                    else passes++;
                end
            end
            if (in_valid && in_ready) begin
                q16.push_back(ref16(a, b, cin));
                sent++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (q16.size() != 0) $display("FAIL b2b_missing got=%0d left want=0", q16.size());
        else passes++;
    endtask

    // ------------------------------------------------------------------
    // Random out_ready with continuous in_valid
    task automatic test_backpressure();
        int sent = 0, rcvd = 0, cyc = 0;
        logic prev_stall = 1'b0;
        logic [17:0] prev_out = '0;
        res16_t exp_r;
        q16.delete();
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        while ((sent < 300 || rcvd < 300) && cyc < 3000) begin
            in_valid  = (sent < 300);
            out_ready = 1'($urandom);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {sum, cout, ovf} !== prev_out)
                    $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, {sum, cout, ovf}, prev_out);
                else passes++;
            end
            checks++;
            if (in_ready !== !(q16.size() == 3 && !out_ready))
                $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !(q16.size() == 3 && !out_ready));
            else passes++;
            if (out_valid && out_ready) begin
                checks++;
                if (q16.size() == 0) $display("FAIL bp_extra_beat cyc=%0d got=beat want=none", cyc);
                else begin
                    exp_r = q16.pop_front();
                    rcvd++;
                    if ({sum, cout, ovf} !== exp_r)
                        $display("FAIL bp_result cyc=%0d got=%h want=%h", cyc, {sum, cout, ovf}, exp_r);
                    else passes++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {sum, cout, ovf};
            if (in_valid && in_ready) begin
                q16.push_back(ref16(a, b, cin));
                sent++;
                @(posedge clk); #1;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != 300 || sent != 300) $display("FAIL bp_count got=%0d/%0d want=300/300", rcvd, sent);
        else passes++;
    endtask

    // ------------------------------------------------------------------
    // Reset with three beats in flight
    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a = 16'(i); b = 16'(i); cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b want=0", out_valid);
        else passes++;
        checks++;
        if ({sum, cout, ovf} !== 18'd0) $display("FAIL rst_mid_outputs got=%h want=0", {sum, cout, ovf});
        else passes++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL rst_mid_stale cyc=%0d got=%b/%b want=0/1", k, out_valid, in_ready);
            else passes++;
            @(posedge clk); #1;
        end
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_lat2 got=%b want=0", out_valid);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || {sum, cout, ovf} !== {16'h1000, 1'b0, 1'b0})
            $display("FAIL rst_mid_next got=%b/%h want=1/%h", out_valid, {sum, cout, ovf}, {16'h1000, 2'b00});
        else passes++;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // WIDTH=4 exhaustive sweep streamed back to back
    task automatic test_exhaustive4();
        int sent = 0, rcvd = 0;
        res4_t exp_r;
        q4.delete();
        out_ready4 = 1'b1;
        for (int k = 0; k < 520; k++) begin
            if (sent < 512) begin
                b4 = 4'(sent); a4 = 4'(sent >> 4); cin4 = 1'(sent >> 8);
                in_valid4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
            if (out_valid4 && out_ready4) begin
                checks++;
                if (q4.size() == 0) $display("FAIL w4_extra_beat cyc=%0d got=beat want=none", k);
                else begin
                    exp_r = q4.pop_front();
                    rcvd++;
                    if ({sum4, cout4, ovf4} !== exp_r)
                        $display("FAIL w4_result cyc=%0d got=%h want=%h", k, {sum4, cout4, ovf4}, exp_r);
                    else passes++;
                end
            end
            if (in_valid4 && in_ready4) begin
                q4.push_back(ref4(a4, b4, cin4));
                sent++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rcvd != 512) $display("FAIL w4_count got=%0d want=512", rcvd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_exhaustive4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
